vga_timing_gen: RTL and testbench

//  Parametrised VGA raster/timing generator driving the DE1-SoC VGA DAC pins from CLOCK_50.

---
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - renderer and VGA DAC signal bundle for vga_timing_gen
interface vga_timing_gen_if #(
  parameter int COLOR_W = 8,
  parameter int X_W     = 10,
  parameter int Y_W     = 10
);
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic               pix_active;
  logic               pix_ce;
  logic               frame_start;
  logic               vblank_start;
  logic               VGA_CLK;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_BLANK_N;
  logic               VGA_SYNC_N;
  logic [7:0]         VGA_R;
  logic [7:0]         VGA_G;
  logic [7:0]         VGA_B;

  modport master (
    input  pix_r, pix_g, pix_b,
    output pix_x, pix_y, pix_active, pix_ce, frame_start, vblank_start,
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output pix_r, pix_g, pix_b,
    input  pix_x, pix_y, pix_active, pix_ce, frame_start, vblank_start,
    input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster/timing generator for the DE1-SoC DAC
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int PAD     = 8 - COLOR_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]   V_ACT_M1 = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [X_W-1:0]   h_cnt;
  logic [Y_W-1:0]   v_cnt;
  logic             pix_ce;
  logic             h_last;
  logic             v_last;
  logic             active;
  logic             vga_clk_q;
  logic             hs_q;
  logic             vs_q;
  logic             blank_n_q;
  logic [7:0]       r_q;
  logic [7:0]       g_q;
  logic [7:0]       b_q;

  assign pix_ce   = (div_cnt == DIV_LAST);
  assign div_next = pix_ce ? '0 : div_cnt + DIV_W'(1);
  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      vga_clk_q <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      div_cnt   <= div_next;
      // Built from the next divider value so VGA_CLK tracks div_cnt with no lag.
      vga_clk_q <= (div_next >= DIV_HALF);
      if (pix_ce) begin
        h_cnt <= h_last ? '0 : h_cnt + X_W'(1);
        if (h_last) begin
          v_cnt <= v_last ? '0 : v_cnt + Y_W'(1);
        end
        // Output stage describes the pixel just finished, keeping sync/blank/colour aligned.
        hs_q      <= (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : ~HS_POL;
        vs_q      <= (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : ~VS_POL;
        blank_n_q <= active;
        r_q       <= active ? (8'(vga.pix_r) << PAD) : 8'd0;
        g_q       <= active ? (8'(vga.pix_g) << PAD) : 8'd0;
        b_q       <= active ? (8'(vga.pix_b) << PAD) : 8'd0;
      end
    end
  end

  assign vga.pix_x        = h_cnt;
  assign vga.pix_y        = v_cnt;
  assign vga.pix_active   = active;
  assign vga.pix_ce       = pix_ce;
  assign vga.frame_start  = pix_ce && h_last && v_last;
  assign vga.vblank_start = pix_ce && h_last && (v_cnt == V_ACT_M1);
  assign vga.VGA_CLK      = vga_clk_q;
  assign vga.VGA_HS       = hs_q;
  assign vga.VGA_VS       = vs_q;
  assign vga.VGA_BLANK_N  = blank_n_q;
  assign vga.VGA_SYNC_N   = 1'b0;
  assign vga.VGA_R        = r_q;
  assign vga.VGA_G        = g_q;
  assign vga.VGA_B        = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default and small timings)
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct packed {
    int d; int ha; int hf; int hsw; int hb; int va; int vf; int vsw; int vb;
    bit hp; bit vp; int cw;
  } cfg_t;
  localparam cfg_t CFG_A = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8};
  localparam cfg_t CFG_B = '{3, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 4};

  vga_timing_gen_if #(.COLOR_W(8), .X_W(10), .Y_W(10)) bus_a ();
  vga_timing_gen_if #(.COLOR_W(4), .X_W(4), .Y_W(3))   bus_b ();

  vga_timing_gen dut_a (
    .CLOCK_50 (clk),
    .reset    (rst_a),
    .vga      (bus_a)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .X_W(4), .Y_W(3)
  ) dut_b (
    .CLOCK_50 (clk),
    .reset    (rst_b),
    .vga      (bus_b)
  );

  // Renderer: red follows x, green is inverted y, blue is random per cycle.
  logic [7:0] rnd_a = 8'd0;
  logic [3:0] rnd_b = 4'd0;
  assign bus_a.pix_r = bus_a.pix_x[7:0];
  assign bus_a.pix_g = ~bus_a.pix_y[7:0];
  assign bus_a.pix_b = rnd_a;
  assign bus_b.pix_r = bus_b.pix_x;
  assign bus_b.pix_g = ~{1'b0, bus_b.pix_y};
  assign bus_b.pix_b = rnd_b;
  always @(negedge clk) begin
    rnd_a = 8'($urandom);
    rnd_b = 4'($urandom);
  end

  logic [63:0] act_a, act_b;
  assign act_a = {11'd0, bus_a.pix_x, bus_a.pix_y, bus_a.pix_active, bus_a.pix_ce,
                  bus_a.frame_start, bus_a.vblank_start, bus_a.VGA_CLK, bus_a.VGA_HS,
                  bus_a.VGA_VS, bus_a.VGA_BLANK_N, bus_a.VGA_SYNC_N,
                  bus_a.VGA_R, bus_a.VGA_G, bus_a.VGA_B};
  assign act_b = {11'd0, 10'(bus_b.pix_x), 10'(bus_b.pix_y), bus_b.pix_active, bus_b.pix_ce,
                  bus_b.frame_start, bus_b.vblank_start, bus_b.VGA_CLK, bus_b.VGA_HS,
                  bus_b.VGA_VS, bus_b.VGA_BLANK_N, bus_b.VGA_SYNC_N,
                  bus_b.VGA_R, bus_b.VGA_G, bus_b.VGA_B};

  // Reference: everything derived from the clock count n since reset release.
  function automatic logic [63:0] model(cfg_t c, int n, int bs);
    int ht, vt, p, ph, x, y, q, qx, qy, mask, pad, r, g, b;
    bit ce, act, fs, vbs, vclk, hs, vs, bl;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    p = n / c.d;
    ph = n % c.d;
    x = p % ht;
    y = (p / ht) % vt;
    ce = (ph == c.d - 1);
    act = (x < c.ha) && (y < c.va);
    fs = ce && (x == ht - 1) && (y == vt - 1);
    vbs = ce && (x == ht - 1) && (y == c.va - 1);
    vclk = (ph >= c.d / 2);
    mask = (1 << c.cw) - 1;
    pad = 8 - c.cw;
    hs = !c.hp; vs = !c.vp; bl = 1'b0; r = 0; g = 0; b = 0;
    if (p >= 1) begin
      q = p - 1;
      qx = q % ht;
      qy = (q / ht) % vt;
      hs = (qx >= c.ha + c.hf && qx < c.ha + c.hf + c.hsw) ? c.hp : !c.hp;
      vs = (qy >= c.va + c.vf && qy < c.va + c.vf + c.vsw) ? c.vp : !c.vp;
      bl = (qx < c.ha) && (qy < c.va);
      if (bl) begin
        r = (qx & mask) << pad;
        g = ((~qy) & mask) << pad;
        b = (bs & mask) << pad;
      end
    end
    return {11'd0, 10'(x), 10'(y), act, ce, fs, vbs, vclk, hs, vs, bl, 1'b0, 8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  int  n_a = 0, n_b = 0;
  bit  val_a = 1'b0, val_b = 1'b0;
  int  bs_a = 0, bs_b = 0;
  always @(posedge clk) begin
    if (rst_a) begin
      n_a <= 0; val_a <= 1'b1;
    end else if (val_a) begin
      if (n_a % CFG_A.d == CFG_A.d - 1) bs_a <= int'(bus_a.pix_b);
      n_a <= n_a + 1;
    end
    if (rst_b) begin
      n_b <= 0; val_b <= 1'b1;
    end else if (val_b) begin
      if (n_b % CFG_B.d == CFG_B.d - 1) bs_b <= int'(bus_b.pix_b);
      n_b <= n_b + 1;
    end
  end

  always @(negedge clk) begin
    if (val_a) chk("model_a", act_a, model(CFG_A, n_a, bs_a));
    if (val_b) chk("model_b", act_b, model(CFG_B, n_b, bs_b));
  end

  typedef struct {
    int n; int x; int y; bit ce; bit vclk; bit hs; bit bl; int r; int g;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [63:0] tpack(int x, int y, bit ce, bit vclk, bit hs, bit bl, int r, int g);
    return {24'd0, 10'(x), 10'(y), ce, vclk, hs, bl, 8'(r), 8'(g)};
  endfunction

  task automatic wait_n_a(input int target);
    int guard = 0;
    while (n_a < target && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    if (n_a != target) chk("wait_timeout_a", 64'(n_a), 64'(target));
  endtask

  initial begin
    int hs_low, bl_high, ce_cnt, clk_high, hs_fall;
    int fs_cnt, vbs_cnt, vs_high, hs_high, b_bl_high, rise0, rise1;
    bit prev;

    tbl[0]  = '{0,    0,   0, 0, 0, 1, 0, 0,   0};
    tbl[1]  = '{1,    0,   0, 1, 1, 1, 0, 0,   0};
    tbl[2]  = '{2,    1,   0, 0, 0, 1, 1, 0,   255};
    tbl[3]  = '{12,   6,   0, 0, 0, 1, 1, 5,   255};
    tbl[4]  = '{513,  256, 0, 1, 1, 1, 1, 255, 255};
    tbl[5]  = '{515,  257, 0, 1, 1, 1, 1, 0,   255};
    tbl[6]  = '{1281, 640, 0, 1, 1, 1, 1, 127, 255};
    tbl[7]  = '{1282, 641, 0, 0, 0, 1, 0, 0,   0};
    tbl[8]  = '{1313, 656, 0, 1, 1, 1, 0, 0,   0};
    tbl[9]  = '{1314, 657, 0, 0, 0, 0, 0, 0,   0};
    tbl[10] = '{1505, 752, 0, 1, 1, 0, 0, 0,   0};
    tbl[11] = '{1506, 753, 0, 0, 0, 1, 0, 0,   0};
    tbl[12] = '{1600, 0,   1, 0, 0, 1, 0, 0,   0};
    tbl[13] = '{1602, 1,   1, 0, 0, 1, 1, 0,   254};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Default timing: landmark cycles of the first line.
    for (int i = 0; i < 14; i++) begin
      wait_n_a(tbl[i].n);
      chk($sformatf("line_vec_n%0d", tbl[i].n),
          tpack(int'(bus_a.pix_x), int'(bus_a.pix_y), bus_a.pix_ce, bus_a.VGA_CLK,
                bus_a.VGA_HS, bus_a.VGA_BLANK_N, int'(bus_a.VGA_R), int'(bus_a.VGA_G)),
          tpack(tbl[i].x, tbl[i].y, tbl[i].ce, tbl[i].vclk, tbl[i].hs, tbl[i].bl,
                tbl[i].r, tbl[i].g));
    end

    // One whole default line measured in clocks.
    wait_n_a(3200);
    hs_low = 0; bl_high = 0; ce_cnt = 0; clk_high = 0; hs_fall = -1; prev = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      if (!bus_a.VGA_HS) hs_low++;
      if (bus_a.VGA_BLANK_N) bl_high++;
      if (bus_a.pix_ce) ce_cnt++;
      if (bus_a.VGA_CLK) clk_high++;
      if (prev && !bus_a.VGA_HS && hs_fall < 0) hs_fall = i;
      prev = bus_a.VGA_HS;
      @(negedge clk);
    end
    chk("line_hs_low_clocks", 64'(hs_low), 64'(192));
    chk("line_blank_n_high", 64'(bl_high), 64'(1280));
    chk("line_pix_ce_count", 64'(ce_cnt), 64'(800));
    chk("line_vga_clk_high", 64'(clk_high), 64'(800));
    chk("line_hs_fall_offset", 64'(hs_fall), 64'(1314));

    // Mid-line reset at h=300.
    wait_n_a(5400);
    chk("pre_reset_x", 64'(bus_a.pix_x), 64'(300));
    rst_a = 1'b1;
    @(negedge clk);
    chk("midline_reset_outputs", act_a,
        {11'd0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0});
    @(negedge clk);
    rst_a = 1'b0;

    // Small timing: three frames from reset.
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    fs_cnt = 0; vbs_cnt = 0; vs_high = 0; hs_high = 0; b_bl_high = 0;
    rise0 = -1; rise1 = -1; prev = 1'b0;
    for (int i = 0; i < 432; i++) begin
      if (bus_b.frame_start) fs_cnt++;
      if (bus_b.vblank_start) vbs_cnt++;
      if (bus_b.VGA_VS) vs_high++;
      if (bus_b.VGA_HS) hs_high++;
      if (bus_b.VGA_BLANK_N) b_bl_high++;
      if (!prev && bus_b.VGA_HS) begin
        if (rise0 < 0) rise0 = i;
        else if (rise1 < 0) rise1 = i;
      end
      prev = bus_b.VGA_HS;
      if (i == 12) chk("small_colour_msb", {40'd0, bus_b.VGA_R, bus_b.VGA_G, 7'd0, bus_b.VGA_BLANK_N},
                       {40'd0, 8'h30, 8'hF0, 7'd0, 1'b1});
      if (i == 15) chk("small_blank_x4", {40'd0, bus_b.VGA_R, bus_b.VGA_G, 7'd0, bus_b.VGA_BLANK_N},
                       64'd0);
      @(negedge clk);
    end
    chk("small_frame_starts", 64'(fs_cnt), 64'(3));
    chk("small_vblank_starts", 64'(vbs_cnt), 64'(3));
    chk("small_vs_high_clocks", 64'(vs_high), 64'(72));
    chk("small_hs_high_clocks", 64'(hs_high), 64'(108));
    chk("small_blank_n_high", 64'(b_bl_high), 64'(108));
    chk("small_hs_first_rise", 64'(rise0), 64'(18));
    chk("small_line_period", 64'(rise1 - rise0), 64'(24));

    // Random resets; the running reference model checks every cycle.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(5, 200)) @(negedge clk);
      rst_b = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_b = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(50, 1500)) @(negedge clk);
      rst_a = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_a = 1'b0;
    end
    repeat (200) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
